// File: rtl/axis_stream_writer_if.sv
// -----------------------------------------------------------------------------
// axi_stream_if
// Minimal AXI-stream bundle shared by stream producers and consumers.
//   data  : beat payload, DATA_WIDTH bits (master -> slave)
//   valid : beat present (master -> slave)
//   last  : final beat of the packet (master -> slave)
//   ready : slave can accept a beat this cycle (slave -> master)
// A beat transfers on a cycle where valid && ready.
// -----------------------------------------------------------------------------
interface axi_stream_if #(
   parameter int unsigned DATA_WIDTH = 32
) ();

   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  last;
   logic                  ready;

   modport master (
      output data,
      output valid,
      output last,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      input  last,
      output ready
   );

endinterface

// File: rtl/axis_stream_writer.sv
// -----------------------------------------------------------------------------
// axis_stream_writer
// AXI-stream sink: each accepted command consumes one packet and writes its
// beats to a single-port memory write port at incrementing word addresses,
// starting at base_addr. At most max_len beats are stored; any excess beats
// of the packet are drained and discarded. Completion is signalled with a
// one-cycle done pulse together with the stored beat count and a truncation
// flag.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   s_axis       input stream (axi_stream_if.slave): data/valid/last in, ready out
//   start        command strobe, only accepted while idle
//   base_addr    first write address, latched on an accepted start
//   max_len      maximum beats to store, latched on an accepted start
//   busy         high whenever a command is in progress (not idle)
//   mem_wr_en    registered memory write strobe
//   mem_wr_addr  registered memory write address (wraps modulo 2^ADDR_WIDTH)
//   mem_wr_data  registered memory write data
//   done         one-cycle completion pulse
//   len          beats stored; valid from done until the next accepted start
//   overflow     packet was truncated; valid from done until the next start
//   checksum     modulo-2^DATA_WIDTH sum of stored beats (see below)
//
// Build option:
//   AXIS_STREAM_WRITER_CHECKSUM_EN  when defined, checksum accumulates every
//   stored beat (drained beats excluded). When undefined, checksum is tied to
//   zero and no accumulator exists.
// -----------------------------------------------------------------------------
module axis_stream_writer #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  rst,
   axi_stream_if.slave           s_axis,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [ADDR_WIDTH:0]   max_len,
   output logic                  busy,
   output logic                  mem_wr_en,
   output logic [ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   output logic                  done,
   output logic [ADDR_WIDTH:0]   len,
   output logic                  overflow,
   output logic [DATA_WIDTH-1:0] checksum
);

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StRecv  = 2'd1;
   localparam logic [1:0] StDrain = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   // ---------------------------------------------------------------------------
   // State and datapath registers
   // ---------------------------------------------------------------------------
   logic [1:0]            r_state,     w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_base,      w_base_nxt;
   logic [ADDR_WIDTH:0]   r_max_len,   w_max_len_nxt;
   logic [ADDR_WIDTH:0]   r_count,     w_count_nxt;
   logic [ADDR_WIDTH:0]   r_len,       w_len_nxt;
   logic                  r_overflow,  w_overflow_nxt;
   logic                  r_wr_en,     w_wr_en_nxt;
   logic [ADDR_WIDTH-1:0] r_wr_addr,   w_wr_addr_nxt;
   logic [DATA_WIDTH-1:0] r_wr_data,   w_wr_data_nxt;

   // ---------------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------------
   logic                  w_ready;
   logic                  w_start_acc;
   logic                  w_recv_hs;
   logic                  w_drain_hs;
   logic [ADDR_WIDTH:0]   w_count_inc;
   logic                  w_hit_max;

   // ready depends only on registered state, so there is no combinational
   // path from valid back to ready.
   assign w_ready     = (r_state == StRecv) || (r_state == StDrain);
   assign w_start_acc = (r_state == StIdle) && start;
   assign w_recv_hs   = (r_state == StRecv) && s_axis.valid;
   assign w_drain_hs  = (r_state == StDrain) && s_axis.valid;
   assign w_count_inc = r_count + 1'b1;
   assign w_hit_max   = (w_count_inc == r_max_len);

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt    = r_state;
      w_base_nxt     = r_base;
      w_max_len_nxt  = r_max_len;
      w_count_nxt    = r_count;
      w_len_nxt      = r_len;
      w_overflow_nxt = r_overflow;
      w_wr_en_nxt    = 1'b0;
      w_wr_addr_nxt  = r_wr_addr;
      w_wr_data_nxt  = r_wr_data;

      unique case (r_state)
         StIdle: begin
            if (start) begin
               w_base_nxt    = base_addr;
               w_max_len_nxt = max_len;
               w_count_nxt   = '0;
               w_len_nxt     = '0;
               // A zero-length command can store nothing: every beat of the
               // packet is a truncated beat.
               if (max_len == '0) begin
                  w_overflow_nxt = 1'b1;
                  w_state_nxt    = StDrain;
               end else begin
                  w_overflow_nxt = 1'b0;
                  w_state_nxt    = StRecv;
               end
            end
         end

         StRecv: begin
            if (s_axis.valid) begin
               w_wr_en_nxt   = 1'b1;
               // Truncating add: the address wraps past the top of memory.
               w_wr_addr_nxt = r_base + r_count[ADDR_WIDTH-1:0];
               w_wr_data_nxt = s_axis.data;
               w_count_nxt   = w_count_inc;
               // last takes priority, so a packet that exactly fills max_len
               // completes cleanly without a drain phase.
               if (s_axis.last) begin
                  w_len_nxt   = w_count_inc;
                  w_state_nxt = StDone;
               end else if (w_hit_max) begin
                  w_overflow_nxt = 1'b1;
                  w_state_nxt    = StDrain;
               end
            end
         end

         StDrain: begin
            if (s_axis.valid && s_axis.last) begin
               w_len_nxt   = r_count;
               w_state_nxt = StDone;
            end
         end

         StDone: begin
            w_state_nxt = StIdle;
         end

         default: begin
            w_state_nxt = StIdle;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_base     <= '0;
         r_max_len  <= '0;
         r_count    <= '0;
         r_len      <= '0;
         r_overflow <= 1'b0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_base     <= w_base_nxt;
         r_max_len  <= w_max_len_nxt;
         r_count    <= w_count_nxt;
         r_len      <= w_len_nxt;
         r_overflow <= w_overflow_nxt;
         r_wr_en    <= w_wr_en_nxt;
         r_wr_addr  <= w_wr_addr_nxt;
         r_wr_data  <= w_wr_data_nxt;
      end
   end

   // ---------------------------------------------------------------------------
   // Optional checksum accumulator
   // ---------------------------------------------------------------------------
`ifdef AXIS_STREAM_WRITER_CHECKSUM_EN
   logic [DATA_WIDTH-1:0] r_checksum, w_checksum_nxt;

   always_comb begin
      w_checksum_nxt = r_checksum;
      if (w_start_acc) begin
         w_checksum_nxt = '0;
      end else if (w_recv_hs) begin
         w_checksum_nxt = r_checksum + s_axis.data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_checksum <= '0;
      end else begin
         r_checksum <= w_checksum_nxt;
      end
   end

   assign checksum = r_checksum;
`else
   assign checksum = '0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign s_axis.ready = w_ready;
   assign busy         = (r_state != StIdle);
   assign done         = (r_state == StDone);
   assign mem_wr_en    = r_wr_en;
   assign mem_wr_addr  = r_wr_addr;
   assign mem_wr_data  = r_wr_data;
   assign len          = r_len;
   assign overflow     = r_overflow;

   // Drain handshakes only steer the FSM; kept as a named term for readability.
   logic w_unused;
   assign w_unused = w_drain_hs;

endmodule

// File: tb/tb_axis_stream_writer.sv
// -----------------------------------------------------------------------------
// tb_axis_stream_writer
// Table-driven bench for axis_stream_writer. Each table row is one command:
// its inputs (base, max_len, beat count, data seed, bubble mask, extra start
// pulses) and the expected len / overflow / checksum. Expected memory writes
// are pushed to a scoreboard queue as beats are driven and popped by a
// monitor whenever mem_wr_en is seen. Reset corner cases are hand-written.
// -----------------------------------------------------------------------------
module tb_axis_stream_writer;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [AW:0]   max_len;
   logic          busy;
   logic          mem_wr_en;
   logic [AW-1:0] mem_wr_addr;
   logic [DW-1:0] mem_wr_data;
   logic          done;
   logic [AW:0]   len;
   logic          overflow;
   logic [DW-1:0] checksum;

   always #5 clk = ~clk;

   axi_stream_if #(.DATA_WIDTH(DW)) u_if ();

   axis_stream_writer #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .s_axis      (u_if),
      .start       (start),
      .base_addr   (base_addr),
      .max_len     (max_len),
      .busy        (busy),
      .mem_wr_en   (mem_wr_en),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .done        (done),
      .len         (len),
      .overflow    (overflow),
      .checksum    (checksum)
   );

   typedef struct {
      logic [AW-1:0] base;
      logic [AW:0]   max_len;
      int            nbeats;
      logic [DW-1:0] data0;
      logic [7:0]    gap_mask;    // bit i: one idle cycle after beat i
      bit            busy_start;  // pulse start with junk command on beat 1
      bit            done_start;  // pulse start with junk command in done cycle
      logic [AW:0]   exp_len;
      bit            exp_ovf;
      logic [DW-1:0] exp_csum;
   } vec_t;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   vec_t vecs [6];
   wr_t  sb_q [$];
   wr_t  mon_e;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   n_done   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: every write must match the oldest expected write.
   always @(negedge clk) begin
      if (mem_wr_en === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("spurious_wr_en", {63'd0, mem_wr_en}, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            check("wr_addr", {54'd0, mem_wr_addr}, {54'd0, mon_e.addr});
            check("wr_data", {32'd0, mem_wr_data}, {32'd0, mon_e.data});
         end
      end
      if (done === 1'b1) n_done++;
   end

   // Waits for a handshake; returns how many cycles ready stayed low first.
   task automatic wait_hs(output int waits);
      waits = 20;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (u_if.ready === 1'b1) begin
            @(posedge clk);
            waits = k;
            return;
         end
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int            waits;
      logic [DW-1:0] d;
      logic [DW-1:0] exp_cs;
      wr_t           e;
`ifdef AXIS_STREAM_WRITER_CHECKSUM_EN
      exp_cs = v.exp_csum;
`else
      exp_cs = '0;
`endif
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = v.base;
      max_len   = v.max_len;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < v.nbeats; i++) begin
         d = v.data0 + DW'(i);
         if (v.busy_start && i == 1) begin
            start     = 1'b1;
            base_addr = ~v.base;
            max_len   = 11'd1;
         end
         u_if.valid = 1'b1;
         u_if.data  = d;
         u_if.last  = (i == v.nbeats - 1);
         if (i < int'(v.max_len)) begin
            e.addr = v.base + AW'(i);
            e.data = d;
            sb_q.push_back(e);
         end
         wait_hs(waits);
         check($sformatf("v%0d_hs_wait_b%0d", idx, i), 64'(waits), 64'd0);
         #1;
         u_if.valid = 1'b0;
         u_if.last  = 1'b0;
         start      = 1'b0;
         if (v.gap_mask[i] && i != v.nbeats - 1) begin
            @(posedge clk);
            #1;
         end
      end
      if (v.done_start) begin
         start     = 1'b1;
         base_addr = 10'h111;
         max_len   = 11'd5;
      end
      // done is due in the cycle right after the final handshake.
      @(negedge clk);
      check($sformatf("v%0d_done", idx), {63'd0, done}, 64'd1);
      check($sformatf("v%0d_len", idx), {53'd0, len}, {53'd0, v.exp_len});
      check($sformatf("v%0d_overflow", idx), {63'd0, overflow}, {63'd0, v.exp_ovf});
      check($sformatf("v%0d_checksum", idx), {32'd0, checksum}, {32'd0, exp_cs});
      @(posedge clk);
      #1;
      start = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_busy_after", idx), {63'd0, busy}, 64'd0);
      check($sformatf("v%0d_done_after", idx), {63'd0, done}, 64'd0);
      check($sformatf("v%0d_len_held", idx), {53'd0, len}, {53'd0, v.exp_len});
      check($sformatf("v%0d_sb_empty", idx), 64'(sb_q.size()), 64'd0);
   endtask

   initial begin
      int  waits;
      int  done_before;
      wr_t e;

      //           base     max     n  data0          gaps   bs    ds    len     ovf   csum
      vecs[0] = '{10'h010, 11'd4, 4, 32'h0000_00A0, 8'h00, 1'b0, 1'b0, 11'd4, 1'b0, 32'h0000_0286};
      vecs[1] = '{10'h020, 11'd2, 5, 32'h0000_00B0, 8'h04, 1'b1, 1'b0, 11'd2, 1'b1, 32'h0000_0161};
      vecs[2] = '{10'h3FE, 11'd4, 4, 32'h0000_00C0, 8'h03, 1'b0, 1'b0, 11'd4, 1'b0, 32'h0000_0306};
      vecs[3] = '{10'h100, 11'd0, 3, 32'h0000_00D0, 8'h00, 1'b1, 1'b0, 11'd0, 1'b1, 32'h0000_0000};
      vecs[4] = '{10'h040, 11'd3, 3, 32'h0000_00E0, 8'h00, 1'b0, 1'b1, 11'd3, 1'b0, 32'h0000_02A3};
      vecs[5] = '{10'h050, 11'd8, 3, 32'hFFFF_FFFE, 8'h00, 1'b0, 1'b0, 11'd3, 1'b0, 32'hFFFF_FFFD};

      rst        = 1'b1;
      start      = 1'b0;
      base_addr  = '0;
      max_len    = '0;
      u_if.valid = 1'b0;
      u_if.data  = '0;
      u_if.last  = 1'b0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy",      {63'd0, busy},       64'd0);
      check("rst_ready",     {63'd0, u_if.ready}, 64'd0);
      check("rst_wr_en",     {63'd0, mem_wr_en},  64'd0);
      check("rst_wr_addr",   {54'd0, mem_wr_addr}, 64'd0);
      check("rst_wr_data",   {32'd0, mem_wr_data}, 64'd0);
      check("rst_done",      {63'd0, done},       64'd0);
      check("rst_len",       {53'd0, len},        64'd0);
      check("rst_overflow",  {63'd0, overflow},   64'd0);
      check("rst_checksum",  {32'd0, checksum},   64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int v = 0; v < 6; v++) begin
         run_vec(vecs[v], v);
      end

      // Reset lands on the 3rd handshake of an 8-beat packet.
      done_before = n_done;
      @(posedge clk);
      #1;
      start     = 1'b1;
      base_addr = 10'h080;
      max_len   = 11'd8;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         u_if.valid = 1'b1;
         u_if.data  = 32'h55 + DW'(i);
         u_if.last  = 1'b0;
         e.addr     = 10'h080 + AW'(i);
         e.data     = 32'h55 + DW'(i);
         sb_q.push_back(e);
         wait_hs(waits);
         check($sformatf("rstmid_hs_wait_b%0d", i), 64'(waits), 64'd0);
         #1;
      end
      u_if.data = 32'h57;
      rst       = 1'b1;
      @(negedge clk);
      check("rstmid_ready_at_beat3", {63'd0, u_if.ready}, 64'd1);
      @(posedge clk);
      #1;
      rst        = 1'b0;
      u_if.valid = 1'b0;
      @(negedge clk);
      check("rstmid_busy",     {63'd0, busy},       64'd0);
      check("rstmid_ready",    {63'd0, u_if.ready}, 64'd0);
      check("rstmid_wr_en",    {63'd0, mem_wr_en},  64'd0);
      check("rstmid_len",      {53'd0, len},        64'd0);
      check("rstmid_overflow", {63'd0, overflow},   64'd0);
      repeat (2) @(negedge clk);
      check("rstmid_no_done",  64'(n_done - done_before), 64'd0);
      check("rstmid_sb_empty", 64'(sb_q.size()), 64'd0);

      // A fresh command after the abandoned packet behaves normally.
      run_vec(vecs[0], 6);

      check("done_pulses", 64'(n_done), 64'd7);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/axis_stream_writer.md
Name: axis_stream_writer

Overview:
- AXI-stream sink. Consumes one packet per command from an upstream stream master and writes each beat to a simple single-port memory write port at incrementing addresses.
- Reports completion, beat count and a truncation flag to a control FSM.
- Receiver end for stream producers such as DMA readers and compute pipelines that drive `axi_stream_if.master`.

Parameters:
- DATA_WIDTH, 32, width of stream data and memory write data.
- ADDR_WIDTH, 10, memory word-address width; buffer depth 2^ADDR_WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- s_axis  interface  axi_stream_if.slave (DATA_WIDTH)  input stream: data, valid, last in; ready out.
- start  input  1  command strobe, sampled only in IDLE.
- base_addr  input  ADDR_WIDTH  first write address, latched on accepted start.
- max_len  input  ADDR_WIDTH+1  maximum beats to store, latched on accepted start.
- busy  output  1  high in every state except IDLE.
- mem_wr_en  output  1  registered write strobe.
- mem_wr_addr  output  ADDR_WIDTH  registered write address.
- mem_wr_data  output  DATA_WIDTH  registered write data.
- done  output  1  one-cycle completion pulse.
- len  output  ADDR_WIDTH+1  beats stored; valid from done, held until next accepted start.
- overflow  output  1  packet truncated; valid from done, held until next accepted start.
- checksum  output  DATA_WIDTH  see Optional Feature.

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- Reset values:
  - all outputs 0;
  - s_axis.ready 0;
  - state IDLE.
- States: IDLE, RECV, DRAIN, DONE.
- IDLE:
  - ready=0, busy=0.
  - start=1 latches base_addr and max_len, clears count, len, overflow and checksum.
  - Next state is RECV; if max_len==0, next state is DRAIN and overflow is set to 1.
- RECV:
  - ready=1. A handshake is valid && ready in the same cycle.
  - Each handshake registers mem_wr_en=1, mem_wr_addr=base+count and mem_wr_data=data for the following cycle; count increments.
  - Address arithmetic is modulo 2^ADDR_WIDTH, so it wraps silently past the top of memory.
- RECV exit:
  - On a handshake with last=1, or with count+1==max_len, the write is issued as normal.
  - last=1 goes to DONE, overflow=0. This includes the case where last=1 and count+1==max_len in the same beat.
  - Reaching max_len with last=0 goes to DRAIN, overflow=1.
- DRAIN:
  - ready=1; beats are consumed and discarded, with no memory writes and no count change.
  - A handshake with last=1 goes to DONE.
- DONE (one cycle):
  - done=1, len=count; next state IDLE.
  - Timing: done is asserted in the same cycle as the final mem_wr_en when the exit was from RECV. It is asserted the cycle after the last handshake when the exit was from DRAIN.
- mem_wr_en is high exactly one cycle per stored beat; it is low in every cycle without a preceding RECV handshake.
- start is ignored when busy=1. start in the DONE cycle is also ignored; it is accepted only in IDLE.
- valid is ignored outside RECV/DRAIN because ready=0 there. data and last are don't-care when valid=0.
- Throughput: one beat per cycle, sustained.
- Reset mid-operation: returns to IDLE with outputs 0 in the next cycle. A handshake coincident with rst=1 produces no write and no done. A partial packet is abandoned, and upstream must restart it.
- Latency: handshake to mem_wr_en is 1 cycle; start to ready=1 is 1 cycle.

Optional Feature:
- Macro AXIS_STREAM_WRITER_CHECKSUM_EN.
- Defined: checksum accumulates the DATA_WIDTH-bit modulo-2^DATA_WIDTH sum of every stored beat. Discarded DRAIN beats are excluded. It is cleared on accepted start, valid from done, and held until the next accepted start.
- Undefined: the checksum port remains present, is driven constant 0, and no accumulator is synthesized.

Test Plan:
1. Basic packet: start with base=0x010, max_len=4, then 4 beats 0xA0..0xA3 with last on the 4th. Required: writes to 0x010..0x013 with matching data, done one cycle after the 4th handshake, len=4, overflow=0, checksum=0x286 (with the macro defined).
2. Truncation: max_len=2, 5-beat packet. Required: writes only to base and base+1, 3 beats drained without writes, done the cycle after the last handshake, len=2, overflow=1.
3. Wrap and backpressure-free bubbles: base=0x3FE, max_len=4, valid toggled 1,0,1,0,1,1. Required: addresses 0x3FE, 0x3FF, 0x000, 0x001, with no writes in bubble cycles.
4. Edge commands: max_len=0 with a 3-beat packet, then start pulsed while busy. Required: for max_len=0, no writes, len=0, overflow=1. The start pulsed while busy is ignored, with base/len unchanged.
5. Reset mid-packet: rst asserted on the 3rd handshake of an 8-beat packet. Required: no write for that beat, busy=0 and ready=0 the next cycle, no done; a new start works normally.
6. Last coincident with max_len: max_len=3, packet with last on beat 3. Required: overflow=0, len=3, no DRAIN cycle.
